// File: rtl/flight_cmd_scheduler_pkg.sv
// Shared types and constants for the flight command scheduler:
// FSM states, frame byte order, channel bundle, and the slew/failsafe helpers.
package flight_cmd_scheduler_pkg;

  localparam logic [7:0] NEUTRAL   = 8'd116;
  localparam logic [7:0] AXIS_MAX  = 8'd174;
  localparam logic [7:0] THR_MIN   = 8'd58;
  localparam logic [7:0] SLEW      = 8'd16;
  localparam logic [7:0] THR_STEP  = 8'd8;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [3:0] ARM_FRAMES = 4'd8;
  localparam logic [2:0] TRACK_TMO  = 3'd5;

  localparam logic signed [8:0] SLEW_S = 9'sd16;

  typedef enum logic [1:0] {
    ST_DISARMED,
    ST_ARMED,
    ST_FAILSAFE
  } state_e;

  typedef enum logic [2:0] {
    BYTE_SYNC,
    BYTE_T,
    BYTE_P,
    BYTE_R,
    BYTE_Y,
    BYTE_CHK
  } byte_idx_e;

  typedef struct packed {
    logic [7:0] t;
    logic [7:0] p;
    logic [7:0] r;
    logic [7:0] y;
  } chan_t;

  localparam chan_t CHAN_SAFE = '{t: THR_MIN, p: NEUTRAL, r: NEUTRAL, y: NEUTRAL};

  // Step cur toward tgt by at most SLEW; the 9-bit difference covers -255..255.
  function automatic logic [7:0] slew_toward(input logic [7:0] cur, input logic [7:0] tgt);
    logic signed [8:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > SLEW_S)       return cur + SLEW;
    else if (diff < -SLEW_S) return cur - SLEW;
    else                     return tgt;
  endfunction

  function automatic chan_t failsafe_step(input chan_t c);
    chan_t n;
    n.p = slew_toward(c.p, NEUTRAL);
    n.r = slew_toward(c.r, NEUTRAL);
    n.y = slew_toward(c.y, NEUTRAL);
    n.t = (c.t >= THR_MIN + THR_STEP) ? c.t - THR_STEP : THR_MIN;
    return n;
  endfunction

  function automatic logic [7:0] frame_chk(input chan_t c);
    return c.t ^ c.p ^ c.r ^ c.y;
  endfunction

endpackage

// File: rtl/flight_cmd_scheduler_if.sv
// Byte-serial valid/ready link from the scheduler to the radio transmitter.
interface flight_cmd_scheduler_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/flight_cmd_scheduler_frame_tx.sv
// Latches one channel snapshot and serializes SYNC,T,P,R,Y,CHK over the valid/ready link.
module flight_cmd_scheduler_frame_tx
  import flight_cmd_scheduler_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          load_i,
  input  chan_t                         chan_i,
  output logic                          busy_o,
  flight_cmd_scheduler_if.master        tx
);

  chan_t      chan_q;
  logic [2:0] idx_q;
  logic [7:0] data_q;
  logic       valid_q;
  logic       last_q;

  logic [2:0] idx_nxt;
  logic [7:0] byte_nxt;

  always_comb begin
    idx_nxt  = idx_q + 3'd1;
    byte_nxt = SYNC_BYTE;
    case (idx_nxt)
      BYTE_T:   byte_nxt = chan_q.t;
      BYTE_P:   byte_nxt = chan_q.p;
      BYTE_R:   byte_nxt = chan_q.r;
      BYTE_Y:   byte_nxt = chan_q.y;
      BYTE_CHK: byte_nxt = frame_chk(chan_q);
      default:  byte_nxt = SYNC_BYTE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chan_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load_i && !valid_q) begin
      chan_q  <= chan_i;
      idx_q   <= BYTE_SYNC;
      data_q  <= SYNC_BYTE;
      valid_q <= 1'b1;
      last_q  <= 1'b0;
    end else if (valid_q && tx.tx_ready) begin
      if (idx_q == BYTE_CHK) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        idx_q  <= idx_nxt;
        data_q <= byte_nxt;
        last_q <= (idx_nxt == BYTE_CHK);
      end
    end
  end

  assign tx.tx_data  = data_q;
  assign tx.tx_valid = valid_q;
  assign tx.tx_last  = last_q;
  assign busy_o      = valid_q;

endmodule

// File: rtl/flight_cmd_scheduler.sv
// Arm/disarm/failsafe sequencing, slew limiting and track timeout for the radio command frames.
module flight_cmd_scheduler
  import flight_cmd_scheduler_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [7:0]             pitch_in,
  input  logic [7:0]             roll_in,
  input  logic [7:0]             yaw_in,
  input  logic [7:0]             throttle_in,
  input  logic                   track_valid,
  input  logic                   frame_tick,
  flight_cmd_scheduler_if.master tx,
  output logic                   armed,
  output logic                   failsafe,
  output logic                   overrun
);

  state_e     state_q, state_d;
  logic [3:0] arm_cnt_q, arm_cnt_d;
  logic [2:0] tmo_q, tmo_d;
  chan_t      chan_q, chan_d;
  logic       armed_q, failsafe_q, overrun_q;

  logic busy;
  logic accept;
  logic gesture_arm;
  logic gesture_disarm;

  assign accept         = frame_tick && !busy;
  assign gesture_arm    = (throttle_in <= THR_MIN) && (yaw_in == AXIS_MAX);
  assign gesture_disarm = (throttle_in <= THR_MIN) && (yaw_in == 8'd0);

  // tmo_d already includes the current tick, so the fifth silent tick trips failsafe itself.
  always_comb begin
    tmo_d = tmo_q;
    if (track_valid)
      tmo_d = '0;
    else if (frame_tick && (tmo_q != TRACK_TMO))
      tmo_d = tmo_q + 3'd1;
  end

  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    chan_d    = chan_q;
    if (accept) begin
      case (state_q)
        ST_DISARMED: begin
          chan_d = CHAN_SAFE;
          if (gesture_arm) begin
            arm_cnt_d = arm_cnt_q + 4'd1;
            if (arm_cnt_d == ARM_FRAMES) begin
              state_d   = ST_ARMED;
              arm_cnt_d = '0;
            end
          end else begin
            arm_cnt_d = '0;
          end
        end
        ST_ARMED: begin
          if (tmo_d == TRACK_TMO) begin
            state_d   = ST_FAILSAFE;
            arm_cnt_d = '0;
            chan_d    = failsafe_step(chan_q);
          end else begin
            chan_d.p = slew_toward(chan_q.p, pitch_in);
            chan_d.r = slew_toward(chan_q.r, roll_in);
            chan_d.y = slew_toward(chan_q.y, yaw_in);
            chan_d.t = (throttle_in < THR_MIN) ? THR_MIN : throttle_in;
            if (gesture_disarm) begin
              arm_cnt_d = arm_cnt_q + 4'd1;
              if (arm_cnt_d == ARM_FRAMES) begin
                state_d   = ST_DISARMED;
                arm_cnt_d = '0;
              end
            end else begin
              arm_cnt_d = '0;
            end
          end
        end
        ST_FAILSAFE: begin
          chan_d = failsafe_step(chan_q);
          if (chan_d.t == THR_MIN)
            state_d = ST_DISARMED;
        end
        default: begin
          state_d   = ST_DISARMED;
          arm_cnt_d = '0;
          chan_d    = CHAN_SAFE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_DISARMED;
      arm_cnt_q  <= '0;
      tmo_q      <= '0;
      chan_q     <= CHAN_SAFE;
      armed_q    <= 1'b0;
      failsafe_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      tmo_q      <= tmo_d;
      chan_q     <= chan_d;
      armed_q    <= (state_d == ST_ARMED);
      failsafe_q <= (state_d == ST_FAILSAFE);
      overrun_q  <= frame_tick && busy;
    end
  end

  flight_cmd_scheduler_frame_tx u_cmd_frame_tx (
    .clock   (clock),
    .reset_n (reset_n),
    .load_i  (accept),
    .chan_i  (chan_d),
    .busy_o  (busy),
    .tx      (tx)
  );

  assign armed    = armed_q;
  assign failsafe = failsafe_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_flight_cmd_scheduler.sv
// Directed bench for flight_cmd_scheduler: frame format, arming, slew, failsafe, stall/overrun, reset abort.
module tb_flight_cmd_scheduler;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] pitch_in, roll_in, yaw_in, throttle_in;
  logic       track_valid, frame_tick;
  logic       armed, failsafe, overrun;

  flight_cmd_scheduler_if txif ();

  flight_cmd_scheduler dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pitch_in    (pitch_in),
    .roll_in     (roll_in),
    .yaw_in      (yaw_in),
    .throttle_in (throttle_in),
    .track_valid (track_valid),
    .frame_tick  (frame_tick),
    .tx          (txif),
    .armed       (armed),
    .failsafe    (failsafe),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;
  logic [7:0] fb [6];
  logic       lb [6];

  task automatic run_frame(input logic tv, input logic [7:0] thr, input logic [7:0] p,
                           input logic [7:0] r, input logic [7:0] y);
    int n;
    int cyc;
    @(negedge clock);
    throttle_in = thr; pitch_in = p; roll_in = r; yaw_in = y;
    track_valid = tv; frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0; track_valid = 1'b0;
    n = 0; cyc = 0;
    while (n < 6 && cyc < 20) begin
      if (txif.tx_valid === 1'b1) begin
        fb[n] = txif.tx_data;
        lb[n] = txif.tx_last;
        n++;
      end
      if (n < 6) @(negedge clock);
      cyc++;
    end
    n_total++;
    if (n != 6) $display("FAIL frame_complete: got %0d bytes, want 6", n);
    else n_pass++;
  endtask

  task automatic test_reset;
    logic [7:0] exp [6];
    exp = '{8'hA5, 8'h3A, 8'h74, 8'h74, 8'h74, 8'h4E};
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_total++;
    if (txif.tx_valid !== 1'b0 || txif.tx_data !== 8'h00 || txif.tx_last !== 1'b0)
      $display("FAIL reset_tx: got valid=%b data=%h last=%b, want 0 00 0",
               txif.tx_valid, txif.tx_data, txif.tx_last);
    else n_pass++;
    n_total++;
    if (armed !== 1'b0 || failsafe !== 1'b0 || overrun !== 1'b0)
      $display("FAIL reset_flags: got armed=%b failsafe=%b overrun=%b, want 0 0 0",
               armed, failsafe, overrun);
    else n_pass++;
    reset_n = 1'b1;
    run_frame(1'b1, 8'd58, 8'd116, 8'd116, 8'd116);
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if (fb[i] !== exp[i] || lb[i] !== (i == 5))
        $display("FAIL reset_frame byte%0d: got %h last=%b, want %h last=%b",
                 i, fb[i], lb[i], exp[i], (i == 5));
      else n_pass++;
    end
    n_total++;
    if (armed !== 1'b0) $display("FAIL reset_frame_armed: got %b want 0", armed);
    else n_pass++;
  endtask

  task automatic test_arming;
    for (int k = 0; k < 4; k++) run_frame(1'b1, 8'd58, 8'd116, 8'd116, 8'd174);
    run_frame(1'b1, 8'd58, 8'd116, 8'd116, 8'd116);
    for (int k = 0; k < 7; k++) run_frame(1'b1, 8'd58, 8'd116, 8'd116, 8'd174);
    n_total++;
    if (armed !== 1'b0) $display("FAIL arm_break_restart: got armed=%b want 0", armed);
    else n_pass++;
    run_frame(1'b1, 8'd58, 8'd116, 8'd116, 8'd174);
    n_total++;
    if (armed !== 1'b1 || failsafe !== 1'b0)
      $display("FAIL arm_eighth: got armed=%b failsafe=%b, want 1 0", armed, failsafe);
    else n_pass++;
    n_total++;
    if (fb[1] !== 8'h3A || fb[4] !== 8'h74)
      $display("FAIL arm_frame_safe: got T=%h Y=%h, want 3a 74", fb[1], fb[4]);
    else n_pass++;
  endtask

  task automatic test_slew;
    logic [7:0] exp_p [4];
    exp_p = '{8'd132, 8'd148, 8'd164, 8'd174};
    for (int k = 0; k < 4; k++) begin
      run_frame(1'b1, 8'd98, 8'd174, 8'd116, 8'd116);
      n_total++;
      if (fb[2] !== exp_p[k] || fb[1] !== 8'd98)
        $display("FAIL slew_up f%0d: got P=%0d T=%0d, want P=%0d T=98", k, fb[2], fb[1], exp_p[k]);
      else n_pass++;
      if (k == 0) begin
        n_total++;
        if (fb[5] !== 8'hE6) $display("FAIL slew_chk0: got %h want e6", fb[5]);
        else n_pass++;
      end
    end
    n_total++;
    if (fb[5] !== 8'hCC) $display("FAIL slew_chk3: got %h want cc", fb[5]);
    else n_pass++;
    run_frame(1'b1, 8'd40, 8'd0, 8'd116, 8'd116);
    n_total++;
    if (fb[1] !== 8'd58 || fb[2] !== 8'd158 || armed !== 1'b1)
      $display("FAIL slew_down_floor: got T=%0d P=%0d armed=%b, want 58 158 1", fb[1], fb[2], armed);
    else n_pass++;
  endtask

  task automatic test_failsafe;
    logic [7:0] exp_t [5];
    logic [7:0] exp_p [5];
    exp_t = '{8'd90, 8'd82, 8'd74, 8'd66, 8'd58};
    exp_p = '{8'd142, 8'd126, 8'd116, 8'd116, 8'd116};
    for (int k = 0; k < 4; k++) run_frame(1'b0, 8'd98, 8'd158, 8'd116, 8'd116);
    n_total++;
    if (armed !== 1'b1 || failsafe !== 1'b0 || fb[1] !== 8'd98 || fb[2] !== 8'd158)
      $display("FAIL fs_pre: got armed=%b fs=%b T=%0d P=%0d, want 1 0 98 158",
               armed, failsafe, fb[1], fb[2]);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      run_frame((k == 2), 8'd98, 8'd158, 8'd116, 8'd116);
      n_total++;
      if (fb[1] !== exp_t[k] || fb[2] !== exp_p[k])
        $display("FAIL fs_seq f%0d: got T=%0d P=%0d, want T=%0d P=%0d",
                 k, fb[1], fb[2], exp_t[k], exp_p[k]);
      else n_pass++;
      n_total++;
      if (failsafe !== (k < 4) || armed !== 1'b0)
        $display("FAIL fs_state f%0d: got fs=%b armed=%b, want fs=%b armed=0",
                 k, failsafe, armed, (k < 4));
      else n_pass++;
    end
  endtask

  task automatic test_stall_overrun;
    logic [7:0] exp_tail [3];
    exp_tail = '{8'h74, 8'h74, 8'h4E};
    @(negedge clock);
    throttle_in = 8'd58; pitch_in = 8'd116; roll_in = 8'd116; yaw_in = 8'd116;
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    n_total++;
    if (txif.tx_valid !== 1'b1 || txif.tx_data !== 8'hA5)
      $display("FAIL stall_sync: got valid=%b data=%h, want 1 a5", txif.tx_valid, txif.tx_data);
    else n_pass++;
    @(negedge clock);
    @(negedge clock);
    tx_ready_drop();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_total++;
      if (txif.tx_valid !== 1'b1 || txif.tx_data !== 8'h74 || txif.tx_last !== 1'b0)
        $display("FAIL stall_hold c%0d: got valid=%b data=%h last=%b, want 1 74 0",
                 i, txif.tx_valid, txif.tx_data, txif.tx_last);
      else n_pass++;
      if (i == 0) begin
        yaw_in = 8'd174; frame_tick = 1'b1;
      end else if (i == 1) begin
        frame_tick = 1'b0;
        n_total++;
        if (overrun !== 1'b1) $display("FAIL overrun_pulse: got %b want 1", overrun);
        else n_pass++;
      end else begin
        n_total++;
        if (overrun !== 1'b0) $display("FAIL overrun_clear: got %b want 0", overrun);
        else n_pass++;
      end
    end
    txif.tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_total++;
      if (txif.tx_data !== exp_tail[i] || txif.tx_last !== (i == 2) || txif.tx_valid !== 1'b1)
        $display("FAIL stall_tail b%0d: got %h last=%b valid=%b, want %h last=%b valid=1",
                 i, txif.tx_data, txif.tx_last, txif.tx_valid, exp_tail[i], (i == 2));
      else n_pass++;
    end
    @(negedge clock);
    n_total++;
    if (txif.tx_valid !== 1'b0) $display("FAIL stall_idle: got valid=%b want 0", txif.tx_valid);
    else n_pass++;
  endtask

  task automatic tx_ready_drop;
    txif.tx_ready = 1'b0;
  endtask

  task automatic test_reset_midframe;
    for (int k = 0; k < 8; k++) run_frame(1'b1, 8'd58, 8'd116, 8'd116, 8'd174);
    n_total++;
    if (armed !== 1'b1) $display("FAIL rearm: got armed=%b want 1", armed);
    else n_pass++;
    @(negedge clock);
    frame_tick = 1'b1; track_valid = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0; track_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_total++;
    if (txif.tx_valid !== 1'b0 || armed !== 1'b0 || txif.tx_data !== 8'h00)
      $display("FAIL reset_abort: got valid=%b armed=%b data=%h, want 0 0 00",
               txif.tx_valid, armed, txif.tx_data);
    else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
    run_frame(1'b1, 8'd98, 8'd174, 8'd116, 8'd116);
    n_total++;
    if (fb[0] !== 8'hA5 || fb[1] !== 8'h3A || fb[2] !== 8'h74 || fb[5] !== 8'h4E || armed !== 1'b0)
      $display("FAIL post_reset_frame: got %h %h %h chk=%h armed=%b, want a5 3a 74 chk=4e armed=0",
               fb[0], fb[1], fb[2], fb[5], armed);
    else n_pass++;
  endtask

  initial begin
    reset_n = 1'b0;
    pitch_in = 8'd116; roll_in = 8'd116; yaw_in = 8'd116; throttle_in = 8'd58;
    track_valid = 1'b0; frame_tick = 1'b0;
    txif.tx_ready = 1'b1;
    test_reset();
    test_arming();
    test_slew();
    test_failsafe();
    test_stall_overrun();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
